bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Shares the single bus interface (BIU bus port) between the instruction fetch path (F) and the
//  load/store/mov path issued by the decoder (LS). Grants one requester at a time and holds the
//  grant until the bus answers. Alternates priority on contention and aborts hung transactions
//  with a timeout. Sits between the FCU/decoder request side and the BIU bus pins.
// PARAMETERS
//  AW       32  address width
//  DW       32  data width
//  TIMEOUT  16  max cycles in BUSY waiting for ready_bus before abort (>=2)
// PORTS
//  clk        in   1   system clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  req_f      in   1   fetch request; held high until done_f
//  addr_f     in   AW  fetch address (read only)
//  req_ls     in   1   load/store request; held high until done_ls
//  we_ls      in   1   1 = store, 0 = load
//  addr_ls    in   AW  load/store address
//  wdata_ls   in   DW  store data
//  gnt_f      out  1   fetch owns bus (BUSY, owner=F)
//  gnt_ls     out  1   load/store owns bus (BUSY, owner=LS)
//  done_f     out  1   1-cycle pulse: fetch transaction finished
//  done_ls    out  1   1-cycle pulse: load/store transaction finished
//  rdata      out  DW  read data captured at completion; valid with done_*
//  err        out  1   1-cycle pulse with done_* when transaction timed out
//  bus_cs     out  1   bus chip select
//  bus_we     out  1   bus write enable
//  bus_addr   out  AW  bus address
//  bus_wdata  out  DW  bus write data
//  bus_rdata  in   DW  bus read data, valid when ready_bus=1
//  ready_bus  in   1   bus transaction complete
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, last_owner=LS, timer=0; every output = 0.
//  All outputs registered. States: IDLE, BUSY, GAP.
//  IDLE: bus_cs=0, gnt_*=0. At an edge with req_f|req_ls:
//   - only one requester -> grant it; both -> grant the one != last_owner (F wins first tie after reset).
//   - Latch bus_addr/bus_we/bus_wdata from the winner (F: we=0, wdata=0); bus_cs=1, gnt_x=1,
//     owner=winner, last_owner=winner, timer=0; go BUSY. Latency: req sampled at edge N -> bus_cs=1 after edge N.
//  BUSY: bus_* held stable; timer increments each edge.
//   - ready_bus=1 at edge: rdata<=bus_rdata (store: rdata<=0), done_owner=1 for one cycle,
//     bus_cs=0, gnt_*=0, go GAP.
//   - else if timer==TIMEOUT-1: abort; rdata<=0, done_owner=1 and err=1 for one cycle, bus_cs=0,
//     gnt_*=0, go GAP. ready_bus on the same edge as the limit wins (normal completion, no err).
//   - Requester dropping req in BUSY is ignored; transaction completes and done still pulses.
//  GAP: one mandatory turnaround cycle, bus_cs=0, requests not sampled; next edge -> IDLE.
//   Gives requesters one cycle to drop req after done; back-to-back grants are >=3 cycles apart.
//  ready_bus in IDLE/GAP is ignored. done_f/done_ls/err never high outside the cycle after completion.
//  gnt_f and gnt_ls never both 1; done_f and done_ls never both 1.
//  timer width = $clog2(TIMEOUT+1); saturates, never wraps.
//  rst asserted mid-BUSY: transaction dropped, no done pulse, all outputs 0 immediately.
// TESTING
//  1 Fetch only: req_f=1, addr_f=0x100, ready_bus after 3 cycles, bus_rdata=0xDEADBEEF
//    -> bus_cs=1, bus_addr=0x100, bus_we=0; done_f pulse, rdata=0xDEADBEEF, err=0.
//  2 Store: req_ls=1, we_ls=1, addr_ls=0x20, wdata_ls=0x55 -> bus_we=1, bus_wdata=0x55, done_ls pulse, rdata=0.
//  3 Contention: req_f and req_ls high together, held -> grants F, LS, F, LS in order; never both gnt high.
//  4 Timeout: TIMEOUT=16, ready_bus stuck 0 -> done_ls and err pulse 16 cycles after bus_cs rises; GAP then IDLE.
//  5 ready_bus on the exact timeout edge -> normal done, err=0; ready_bus pulsed in IDLE -> no done.
//  6 rst asserted mid-BUSY -> all outputs 0 immediately; after release, F wins the first tie.

Source files
------------

// File: rtl/bus_arbiter.sv
// ============================================================================
// bus_arbiter : shares one bus port between fetch (F) and load/store (LS),
//               alternating priority on contention, with transaction timeout.
// Rev 1.0
// ============================================================================
`default_nettype none

module bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_f,
  input  logic [AW-1:0] addr_f,
  input  logic          req_ls,
  input  logic          we_ls,
  input  logic [AW-1:0] addr_ls,
  input  logic [DW-1:0] wdata_ls,
  output logic          gnt_f,
  output logic          gnt_ls,
  output logic          done_f,
  output logic          done_ls,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          bus_cs,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  input  logic          ready_bus
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          owner_ls_q, owner_ls_d;
  logic          last_ls_q, last_ls_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          gnt_f_q, gnt_f_d;
  logic          gnt_ls_q, gnt_ls_d;
  logic          done_f_q, done_f_d;
  logic          done_ls_q, done_ls_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          bus_cs_q, bus_cs_d;
  logic          bus_we_q, bus_we_d;
  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic [DW-1:0] bus_wdata_q, bus_wdata_d;

  // LS wins when it is the sole requester, or on a tie when F went last.
  logic win_ls;
  assign win_ls = req_ls & (~req_f | ~last_ls_q);

  always_comb begin
    state_d     = state_q;
    owner_ls_d  = owner_ls_q;
    last_ls_d   = last_ls_q;
    timer_d     = timer_q;
    gnt_f_d     = gnt_f_q;
    gnt_ls_d    = gnt_ls_q;
    done_f_d    = 1'b0;
    done_ls_d   = 1'b0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    bus_cs_d    = bus_cs_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_f | req_ls) begin
          owner_ls_d  = win_ls;
          last_ls_d   = win_ls;
          timer_d     = '0;
          gnt_f_d     = ~win_ls;
          gnt_ls_d    = win_ls;
          bus_cs_d    = 1'b1;
          bus_we_d    = win_ls & we_ls;
          bus_addr_d  = win_ls ? addr_ls : addr_f;
          bus_wdata_d = win_ls ? wdata_ls : '0;
          state_d     = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (timer_q != TIMER_MAX) begin
          timer_d = timer_q + TW'(1);
        end
        if (ready_bus || (timer_q == TIMER_LAST)) begin
          // A bus answer on the limit edge counts as normal completion.
          rdata_d   = (ready_bus && !bus_we_q) ? bus_rdata : '0;
          err_d     = ~ready_bus;
          done_f_d  = ~owner_ls_q;
          done_ls_d = owner_ls_q;
          gnt_f_d   = 1'b0;
          gnt_ls_d  = 1'b0;
          bus_cs_d  = 1'b0;
          state_d   = ST_GAP;
        end
      end

      ST_GAP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d  = ST_IDLE;
        gnt_f_d  = 1'b0;
        gnt_ls_d = 1'b0;
        bus_cs_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_ls_q  <= 1'b0;
      last_ls_q   <= 1'b1;
      timer_q     <= '0;
      gnt_f_q     <= 1'b0;
      gnt_ls_q    <= 1'b0;
      done_f_q    <= 1'b0;
      done_ls_q   <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      bus_cs_q    <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_ls_q  <= owner_ls_d;
      last_ls_q   <= last_ls_d;
      timer_q     <= timer_d;
      gnt_f_q     <= gnt_f_d;
      gnt_ls_q    <= gnt_ls_d;
      done_f_q    <= done_f_d;
      done_ls_q   <= done_ls_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      bus_cs_q    <= bus_cs_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign gnt_f     = gnt_f_q;
  assign gnt_ls    = gnt_ls_q;
  assign done_f    = done_f_q;
  assign done_ls   = done_ls_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign bus_cs    = bus_cs_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
// tb_bus_arbiter : table vectors, hand-written corner sequences and random
//                  traffic checked against a transaction-level model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;
  localparam int OW      = 7 + AW + 2 * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_f = 1'b0, req_ls = 1'b0, we_ls = 1'b0, ready_bus = 1'b0;
  logic [AW-1:0] addr_f = '0, addr_ls = '0;
  logic [DW-1:0] wdata_ls = '0, bus_rdata = '0;
  logic          gnt_f, gnt_ls, done_f, done_ls, err, bus_cs, bus_we;
  logic [DW-1:0] rdata, bus_wdata;
  logic [AW-1:0] bus_addr;

  always #5 clk = ~clk;

  bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_f(req_f), .addr_f(addr_f),
    .req_ls(req_ls), .we_ls(we_ls), .addr_ls(addr_ls), .wdata_ls(wdata_ls),
    .gnt_f(gnt_f), .gnt_ls(gnt_ls), .done_f(done_f), .done_ls(done_ls),
    .rdata(rdata), .err(err),
    .bus_cs(bus_cs), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .ready_bus(ready_bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Transaction-level reference: owner 0=none 1=F 2=LS, age = edges spent waiting.
  int            m_owner, m_age, m_last;
  bit            m_gap;
  logic          e_gnt_f, e_gnt_ls, e_done_f, e_done_ls, e_err, e_cs, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rdata;

  function automatic logic [OW-1:0] mk(logic gf, logic gl, logic df, logic dl, logic e,
                                       logic cs, logic we, logic [AW-1:0] a,
                                       logic [DW-1:0] wd, logic [DW-1:0] rd);
    return {gf, gl, df, dl, e, cs, we, a, wd, rd};
  endfunction

  function automatic logic [OW-1:0] pack_dut();
    return mk(gnt_f, gnt_ls, done_f, done_ls, err, bus_cs, bus_we, bus_addr, bus_wdata, rdata);
  endfunction

  function automatic logic [OW-1:0] pack_exp();
    return mk(e_gnt_f, e_gnt_ls, e_done_f, e_done_ls, e_err, e_cs, e_we, e_addr, e_wdata, e_rdata);
  endfunction

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_age = 0; m_last = 2; m_gap = 0;
    {e_gnt_f, e_gnt_ls, e_done_f, e_done_ls, e_err, e_cs, e_we} = '0;
    e_addr = '0; e_wdata = '0; e_rdata = '0;
  endtask

  task automatic model_edge();
    int win;
    e_done_f = 0; e_done_ls = 0; e_err = 0;
    if (rst) begin
      model_reset();
    end else if (m_gap) begin
      m_gap = 0;
    end else if (m_owner == 0) begin
      if (req_f || req_ls) begin
        win = (req_f && req_ls) ? ((m_last == 1) ? 2 : 1) : (req_f ? 1 : 2);
        m_owner = win; m_last = win; m_age = 0;
        e_cs = 1; e_gnt_f = (win == 1); e_gnt_ls = (win == 2);
        e_addr  = (win == 1) ? addr_f : addr_ls;
        e_we    = (win == 1) ? 1'b0 : we_ls;
        e_wdata = (win == 1) ? '0 : wdata_ls;
      end
    end else begin
      m_age++;
      if (ready_bus || m_age == TIMEOUT) begin
        e_done_f  = (m_owner == 1);
        e_done_ls = (m_owner == 2);
        e_err     = !ready_bus;
        e_rdata   = (ready_bus && !e_we) ? bus_rdata : '0;
        e_cs = 0; e_gnt_f = 0; e_gnt_ls = 0;
        m_owner = 0; m_gap = 1;
      end
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check("model", pack_dut(), pack_exp());
  endtask

  task automatic set_in(logic rf, logic rl, logic we, logic [AW-1:0] af, logic [AW-1:0] al,
                        logic [DW-1:0] wd, logic rdy, logic [DW-1:0] brd);
    req_f = rf; req_ls = rl; we_ls = we; addr_f = af; addr_ls = al;
    wdata_ls = wd; ready_bus = rdy; bus_rdata = brd;
  endtask

  typedef struct {
    logic          rf, rl, we;
    logic [AW-1:0] af, al;
    logic [DW-1:0] wd;
    logic          rdy;
    logic [DW-1:0] brd;
    logic [OW-1:0] exp;
  } vec_t;

  vec_t tbl[16];

  initial begin
    // fetch, 3-cycle read
    tbl[0]  = '{1, 0, 0, 32'h100, 0, 0, 0, 0,            mk(1,0,0,0,0,1,0,32'h100,0,0)};
    tbl[1]  = '{1, 0, 0, 32'h100, 0, 0, 0, 0,            mk(1,0,0,0,0,1,0,32'h100,0,0)};
    tbl[2]  = '{1, 0, 0, 32'h100, 0, 0, 0, 0,            mk(1,0,0,0,0,1,0,32'h100,0,0)};
    tbl[3]  = '{1, 0, 0, 32'h100, 0, 0, 1, 32'hDEADBEEF, mk(0,0,1,0,0,0,0,32'h100,0,32'hDEADBEEF)};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0,                  mk(0,0,0,0,0,0,0,32'h100,0,32'hDEADBEEF)};
    // store
    tbl[5]  = '{0, 1, 1, 0, 32'h20, 32'h55, 0, 0,        mk(0,1,0,0,0,1,1,32'h20,32'h55,32'hDEADBEEF)};
    tbl[6]  = '{0, 1, 1, 0, 32'h20, 32'h55, 1, 32'h12345678, mk(0,0,0,1,0,0,1,32'h20,32'h55,0)};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0,                  mk(0,0,0,0,0,0,1,32'h20,32'h55,0)};
    // ready_bus while idle is ignored
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 1, 32'hFFFF,           mk(0,0,0,0,0,0,1,32'h20,32'h55,0)};
    // contention held: F (LS went last), then LS, then F
    tbl[9]  = '{1, 1, 0, 32'h200, 32'h300, 32'h77, 0, 0,     mk(1,0,0,0,0,1,0,32'h200,0,0)};
    tbl[10] = '{1, 1, 0, 32'h200, 32'h300, 32'h77, 1, 32'hA1, mk(0,0,1,0,0,0,0,32'h200,0,32'hA1)};
    tbl[11] = '{1, 1, 0, 32'h200, 32'h300, 32'h77, 0, 0,     mk(0,0,0,0,0,0,0,32'h200,0,32'hA1)};
    tbl[12] = '{1, 1, 0, 32'h200, 32'h300, 32'h77, 0, 0,     mk(0,1,0,0,0,1,0,32'h300,32'h77,32'hA1)};
    tbl[13] = '{1, 1, 0, 32'h200, 32'h300, 32'h77, 1, 32'hB2, mk(0,0,0,1,0,0,0,32'h300,32'h77,32'hB2)};
    tbl[14] = '{1, 1, 0, 32'h200, 32'h300, 32'h77, 0, 0,     mk(0,0,0,0,0,0,0,32'h300,32'h77,32'hB2)};
    tbl[15] = '{1, 1, 0, 32'h200, 32'h300, 32'h77, 0, 0,     mk(1,0,0,0,0,1,0,32'h200,0,32'hB2)};

    model_reset();
    #1;
    check("reset_async", pack_dut(), '0);
    repeat (2) @(posedge clk);
    #2 rst = 0;

    for (int i = 0; i < 16; i++) begin
      set_in(tbl[i].rf, tbl[i].rl, tbl[i].we, tbl[i].af, tbl[i].al, tbl[i].wd, tbl[i].rdy, tbl[i].brd);
      cycle();
      check($sformatf("table[%0d]", i), pack_dut(), tbl[i].exp);
    end
    set_in(0, 0, 0, 0, 0, 0, 1, 32'hC3);
    cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(); cycle();

    // timeout on a stuck bus
    set_in(0, 1, 0, 0, 32'h40, 0, 0, 0);
    cycle();
    check("to_grant", {bus_cs, gnt_ls}, 2'b11);
    for (int k = 1; k <= TIMEOUT; k++) begin
      cycle();
      if (k < TIMEOUT) check($sformatf("to_wait%0d", k), {bus_cs, done_ls, err}, 3'b100);
      else             check("to_abort", {bus_cs, done_ls, err, gnt_ls}, 4'b0110);
    end
    req_ls = 0;
    cycle();
    check("to_gap", {bus_cs, done_ls, err}, 3'b000);
    cycle();

    // ready_bus on the exact limit edge completes normally
    set_in(0, 1, 1, 0, 32'h44, 32'h9, 0, 0);
    cycle();
    for (int k = 1; k <= TIMEOUT; k++) begin
      ready_bus = (k == TIMEOUT);
      cycle();
    end
    check("limit_done", {done_ls, err, bus_cs}, 3'b100);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(); cycle();

    // reset mid-BUSY, then F must win the first tie
    set_in(1, 0, 0, 32'h500, 0, 0, 0, 0);
    cycle();
    check("pre_rst_busy", {gnt_f, bus_cs}, 2'b11);
    #3 rst = 1;
    #1;
    check("rst_midbusy", pack_dut(), '0);
    model_reset();
    @(posedge clk);
    #2 rst = 0;
    set_in(1, 1, 0, 32'h600, 32'h700, 0, 0, 0);
    cycle();
    check("post_rst_tie", {gnt_f, gnt_ls, bus_addr}, {2'b10, 32'h600});
    set_in(0, 0, 0, 0, 0, 0, 1, 32'h1);
    cycle(); cycle(); cycle();

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      req_f     = ($urandom_range(0, 2) != 0);
      req_ls    = ($urandom_range(0, 2) != 0);
      we_ls     = $urandom_range(0, 1);
      addr_f    = $urandom;
      addr_ls   = $urandom;
      wdata_ls  = $urandom;
      bus_rdata = $urandom;
      ready_bus = (n < 2000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      cycle();
      if (gnt_f && gnt_ls) check("gnt_exclusive", 1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
